// File: rtl/exc_pkg.sv
// Shared encodings and default constants for the memory-exception controller,
// so PC-select, CSR and flush logic agree on causes, vectors and regions.
package exc_pkg;

    typedef enum logic [1:0] {
        EXC_NONE = 2'b00,
        EXC_INV  = 2'b01,
        EXC_PROT = 2'b10
    } exc_cause_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_FLUSH    = 2'b01,
        ST_REDIRECT = 2'b10
    } exc_state_t;

    localparam logic [31:0] DEF_INV_BASE     = 32'h0010_0000;
    localparam logic [31:0] DEF_PROT_LO      = 32'h0000_FF00;
    localparam logic [31:0] DEF_PROT_HI      = 32'h0001_0000;
    localparam logic [31:0] DEF_VEC_INV      = 32'h0000_0002;
    localparam logic [31:0] DEF_VEC_PROT     = 32'h0000_0004;
    localparam int          DEF_FLUSH_CYCLES = 2;

endpackage

// File: rtl/mem_exception_ctrl_if.sv
// Memory-stage / flush / PC-select bundle seen by the exception controller.
interface mem_exception_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int PC_W   = 32,
    parameter int CNT_W  = 8
);
    logic              i_mem_read;
    logic              i_mem_write;
    logic [ADDR_W-1:0] i_address;
    logic [PC_W-1:0]   i_pc;
    logic              i_redirect_ack;
    logic              i_cnt_clear;
    logic [1:0]        o_cause;
    logic [PC_W-1:0]   o_epc;
    logic              o_flush;
    logic              o_redirect;
    logic [PC_W-1:0]   o_vector;
    logic              o_busy;
    logic [CNT_W-1:0]  o_cnt_inv;
    logic [CNT_W-1:0]  o_cnt_prot;

    modport slave (
        input  i_mem_read, i_mem_write, i_address, i_pc, i_redirect_ack, i_cnt_clear,
        output o_cause, o_epc, o_flush, o_redirect, o_vector, o_busy, o_cnt_inv, o_cnt_prot
    );

    modport master (
        output i_mem_read, i_mem_write, i_address, i_pc, i_redirect_ack, i_cnt_clear,
        input  o_cause, o_epc, o_flush, o_redirect, o_vector, o_busy, o_cnt_inv, o_cnt_prot
    );
endinterface

// File: rtl/exc_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module exc_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_exception_ctrl.sv
// Memory-stage exception controller: classifies accesses, latches EPC/cause,
// sequences flush then redirect toward fetch, and keeps per-cause statistics.
//
// state    | meaning
// IDLE     | watching memory-stage accesses for faults
// FLUSH    | o_flush held for FLUSH_CYCLES cycles
// REDIRECT | o_redirect asserted with handler vector until fetch acks
module mem_exception_ctrl
    import exc_pkg::*;
#(
    parameter int          ADDR_W       = 32,
    parameter int          PC_W         = 32,
    parameter logic [31:0] INV_BASE     = DEF_INV_BASE,
    parameter logic [31:0] PROT_LO      = DEF_PROT_LO,
    parameter logic [31:0] PROT_HI      = DEF_PROT_HI,
    parameter logic [31:0] VEC_INV      = DEF_VEC_INV,
    parameter logic [31:0] VEC_PROT     = DEF_VEC_PROT,
    parameter int          FLUSH_CYCLES = DEF_FLUSH_CYCLES,
    parameter int          CNT_W        = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_exception_ctrl_if.slave  bus
);

    localparam logic [ADDR_W-1:0] INV_A      = ADDR_W'(INV_BASE);
    localparam logic [ADDR_W-1:0] PROT_LO_A  = ADDR_W'(PROT_LO);
    localparam logic [ADDR_W-1:0] PROT_HI_A  = ADDR_W'(PROT_HI);
    localparam logic [PC_W-1:0]   VEC_INV_P  = PC_W'(VEC_INV);
    localparam logic [PC_W-1:0]   VEC_PROT_P = PC_W'(VEC_PROT);
    localparam logic [3:0]        FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    exc_state_t      state_q, state_d;
    logic [3:0]      fcnt_q, fcnt_d;
    exc_cause_t      cause_q;
    logic [PC_W-1:0] epc_q;
    exc_cause_t      det_cause;
    logic            accept;

    // Invalid outranks protected; both protected bounds are exclusive.
    always_comb begin
        det_cause = EXC_NONE;
        if (bus.i_mem_read || bus.i_mem_write) begin
            if (bus.i_address >= INV_A) begin
                det_cause = EXC_INV;
            end else if ((bus.i_address > PROT_LO_A) && (bus.i_address < PROT_HI_A)) begin
                det_cause = EXC_PROT;
            end
        end
    end

    assign accept = (state_q == ST_IDLE) && (det_cause != EXC_NONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            fcnt_q  <= '0;
            cause_q <= EXC_NONE;
            epc_q   <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            if (accept) begin
                cause_q <= det_cause;
                epc_q   <= bus.i_pc;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_FLUSH;
                    fcnt_d  = FLUSH_LOAD;
                end
            end
            ST_FLUSH: begin
                if (fcnt_q == 4'd0) begin
                    state_d = ST_REDIRECT;
                end else begin
                    fcnt_d = fcnt_q - 4'd1;
                end
            end
            ST_REDIRECT: begin
                if (bus.i_redirect_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.o_flush    = (state_q == ST_FLUSH);
    assign bus.o_redirect = (state_q == ST_REDIRECT);
    assign bus.o_busy     = (state_q != ST_IDLE);
    assign bus.o_cause    = cause_q;
    assign bus.o_epc      = epc_q;
    assign bus.o_vector   = (state_q != ST_REDIRECT) ? '0 :
                            (cause_q == EXC_INV)      ? VEC_INV_P : VEC_PROT_P;

    exc_sat_counter #(.CNT_W(CNT_W)) u_cnt_inv (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (accept && (det_cause == EXC_INV)),
        .clr   (bus.i_cnt_clear),
        .count (bus.o_cnt_inv)
    );

    exc_sat_counter #(.CNT_W(CNT_W)) u_cnt_prot (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (accept && (det_cause == EXC_PROT)),
        .clr   (bus.i_cnt_clear),
        .count (bus.o_cnt_prot)
    );

endmodule

// File: tb/tb_mem_exception_ctrl.sv
// Bench for mem_exception_ctrl: directed scenarios then random traffic,
// all compared against a timeline model of the fault/flush/redirect rules.
module tb_mem_exception_ctrl;

    localparam int FC     = 2;
    localparam int CW     = 2;
    localparam int CNTMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_exception_ctrl_if #(.ADDR_W(32), .PC_W(32), .CNT_W(CW)) bus ();

    mem_exception_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: a fault accepted at edge m_acc flushes after edges m_acc..m_acc+FC-1,
    // then redirects until an ack is sampled while redirecting.
    bit          m_active;
    int          m_acc;
    int          ne;
    logic [31:0] m_epc;
    logic [1:0]  m_cause;
    int          m_cinv, m_cprot;
    bit          e_flush, e_redir;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] classify(input bit rd, input bit wr, input logic [31:0] a);
        if (!(rd || wr)) return 2'd0;
        if (a >= 32'h0010_0000) return 2'd1;
        if (a > 32'h0000_FF00 && a < 32'h0001_0000) return 2'd2;
        return 2'd0;
    endfunction

    task automatic model_reset();
        m_active = 0; m_acc = 0; m_epc = '0; m_cause = '0;
        m_cinv = 0; m_cprot = 0; e_flush = 0; e_redir = 0;
    endtask

    task automatic model_edge(input bit rd, input bit wr, input logic [31:0] addr,
                              input logic [31:0] pc, input bit ack, input bit clr);
        logic [1:0] c;
        c = classify(rd, wr, addr);
        if (!m_active && c != 2'd0) begin
            m_active = 1; m_acc = ne + 1; m_epc = pc; m_cause = c;
            if (c == 2'd1) m_cinv  = (m_cinv  < CNTMAX) ? m_cinv + 1  : CNTMAX;
            else           m_cprot = (m_cprot < CNTMAX) ? m_cprot + 1 : CNTMAX;
        end else if (m_active && ne >= m_acc + FC && ack) begin
            m_active = 0;
        end
        if (clr) begin m_cinv = 0; m_cprot = 0; end
        ne++;
        e_flush = m_active && (ne < m_acc + FC);
        e_redir = m_active && (ne >= m_acc + FC);
    endtask

    task automatic check_all(input string pfx);
        check({pfx, "_flush"},    bus.o_flush,    e_flush);
        check({pfx, "_redirect"}, bus.o_redirect, e_redir);
        check({pfx, "_busy"},     bus.o_busy,     m_active);
        check({pfx, "_cause"},    bus.o_cause,    m_cause);
        check({pfx, "_epc"},      bus.o_epc,      m_epc);
        check({pfx, "_cnt_inv"},  bus.o_cnt_inv,  m_cinv);
        check({pfx, "_cnt_prot"}, bus.o_cnt_prot, m_cprot);
        if (e_redir) check({pfx, "_vector"}, bus.o_vector, (m_cause == 2'd1) ? 2 : 4);
    endtask

    task automatic step(input string pfx, input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] pc, input bit ack, input bit clr);
        @(negedge clk);
        bus.i_mem_read = rd; bus.i_mem_write = wr; bus.i_address = addr;
        bus.i_pc = pc; bus.i_redirect_ack = ack; bus.i_cnt_clear = clr;
        model_edge(rd, wr, addr, pc, ack, clr);
        @(posedge clk);
        #1;
        check_all(pfx);
    endtask

    task automatic idle(input string pfx, input int n);
        for (int i = 0; i < n; i++) step(pfx, 0, 0, 32'h0, 32'h0, 0, 0);
    endtask

    // Advance with ack low until the model expects REDIRECT (bounded).
    task automatic to_redirect(input string pfx);
        for (int i = 0; i < 20 && !e_redir; i++) step(pfx, 0, 0, 32'h0, 32'h0, 0, 0);
    endtask

    task automatic finish_seq(input string pfx);
        to_redirect(pfx);
        step(pfx, 0, 0, 32'h0, 32'h0, 1, 0);
    endtask

    task automatic async_reset(input string pfx);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all(pfx);
        check({pfx, "_vector"}, bus.o_vector, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [31:0] bnd_addr [5];
    logic [31:0] ra;

    initial begin
        bus.i_mem_read = 0; bus.i_mem_write = 0; bus.i_address = '0;
        bus.i_pc = '0; bus.i_redirect_ack = 0; bus.i_cnt_clear = 0;
        ne = 0;
        model_reset();
        #1;
        check_all("rst");
        check("rst_vector", bus.o_vector, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle("idle", 2);

        // Invalid load
        step("inv_fault", 1, 0, 32'h0010_0000, 32'h40, 0, 0);
        check("inv_flush_first", bus.o_flush, 1);
        step("inv_fl2", 0, 0, 32'h0, 32'h0, 0, 0);
        check("inv_flush_second", bus.o_flush, 1);
        step("inv_rd", 0, 0, 32'h0, 32'h0, 0, 0);
        check("inv_redirect", bus.o_redirect, 1);
        check("inv_vector", bus.o_vector, 32'h2);
        check("inv_epc", bus.o_epc, 32'h40);
        step("inv_ack", 0, 0, 32'h0, 32'h0, 1, 0);
        check("inv_redirect_drop", bus.o_redirect, 0);
        check("inv_cnt", bus.o_cnt_inv, 1);

        // Protected-window bounds with stores
        bnd_addr[0] = 32'h0000_FF00; bnd_addr[1] = 32'h0000_FF01; bnd_addr[2] = 32'h0000_FFFF;
        bnd_addr[3] = 32'h0001_0000; bnd_addr[4] = 32'h000F_FFFF;
        foreach (bnd_addr[i]) begin
            step("bnd", 0, 1, bnd_addr[i], 32'h100 + i, 0, 0);
            if (m_active) finish_seq("bnd_seq");
            idle("bnd_idle", 1);
        end

        // Gating and busy
        step("gate", 0, 0, 32'h0020_0000, 32'h200, 0, 0);
        step("busy_first", 0, 1, 32'h0000_FF80, 32'h300, 0, 0);
        step("busy_second", 1, 0, 32'h0030_0000, 32'h304, 0, 0);
        step("busy_third", 0, 1, 32'h0000_FF90, 32'h308, 1, 0);
        check("busy_epc_hold", bus.o_epc, 32'h300);
        finish_seq("busy_seq");

        // Saturation and clear-vs-increment
        for (int k = 0; k < 4; k++) begin
            step("sat_fault", 1, 0, 32'hFFFF_0000, 32'h400 + k, 0, 0);
            finish_seq("sat_seq");
        end
        check("sat_cnt", bus.o_cnt_inv, CNTMAX);
        step("clr_fault", 1, 0, 32'h0010_0004, 32'h500, 0, 1);
        check("clr_cnt", bus.o_cnt_inv, 0);
        finish_seq("clr_seq");

        // Ack timing
        step("ackt_fault", 0, 1, 32'h0000_FFF0, 32'h600, 0, 0);
        step("ackt_in_flush", 0, 0, 32'h0, 32'h0, 1, 0);
        to_redirect("ackt_wait");
        idle("ackt_hold", 5);
        check("ackt_still_redirect", bus.o_redirect, 1);
        step("ackt_ack", 0, 0, 32'h0, 32'h0, 1, 0);
        step("ackt_refault", 1, 0, 32'h0010_0008, 32'h700, 0, 0);
        check("ackt_refault_epc", bus.o_epc, 32'h700);

        // Reset mid-redirect, then clean restart
        to_redirect("mid_wait");
        async_reset("mid_rst");
        step("post_rst_fault", 0, 1, 32'h0000_FF02, 32'h800, 0, 0);
        finish_seq("post_rst_seq");

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            case ($urandom_range(0, 7))
                0: ra = 32'h0000_FF00;
                1: ra = 32'h0000_FF01;
                2: ra = 32'h0000_FFFF;
                3: ra = 32'h0001_0000;
                4: ra = 32'h000F_FFFF;
                5: ra = 32'h0010_0000;
                6: ra = $urandom();
                default: ra = $urandom_range(32'hFE00, 32'h1_0100);
            endcase
            step("rnd", $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, ra,
                 $urandom(), $urandom_range(0, 2) == 0, $urandom_range(0, 30) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
